// File: rtl/conv_disp_pkg.sv
// ---------------------------------------------------------------------------
// conv_disp_pkg
// Shared constants for the convolution-result collector and its display
// consumer: result count/width, FSM state encoding and the mapping from beat
// index to named result slot.
// ---------------------------------------------------------------------------
package conv_disp_pkg;

  localparam int NUM_RESULTS = 8;
  localparam int RES_W       = 8;
  localparam int IDX_W       = $clog2(NUM_RESULTS);
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Beat index -> result slot. The 2x2 results arrive first, then the 3x3.
  localparam logic [IDX_W-1:0] IDX_C11_2X2 = 3'd0;
  localparam logic [IDX_W-1:0] IDX_C12_2X2 = 3'd1;
  localparam logic [IDX_W-1:0] IDX_C21_2X2 = 3'd2;
  localparam logic [IDX_W-1:0] IDX_C22_2X2 = 3'd3;
  localparam logic [IDX_W-1:0] IDX_C11_3X3 = 3'd4;
  localparam logic [IDX_W-1:0] IDX_C12_3X3 = 3'd5;
  localparam logic [IDX_W-1:0] IDX_C21_3X3 = 3'd6;
  localparam logic [IDX_W-1:0] IDX_C22_3X3 = 3'd7;

  // Final beat of a frame; its transfer always triggers publication.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_C22_3X3;

endpackage

// File: rtl/result_shadow_regs.sv
// ---------------------------------------------------------------------------
// result_shadow_regs
// 8 x 8-bit write-by-index buffer with a flat parallel read port. Holds the
// frame being collected so the published outputs stay stable meanwhile.
//   clk, reset : clock, asynchronous active-low reset
//   wr_en      : write wr_data into entry wr_idx
//   wr_idx     : entry to write
//   wr_data    : byte to write
//   clr        : zero every entry (wins over wr_en)
//   rd_data    : all entries, entry i at bits [i*RES_W +: RES_W]
// ---------------------------------------------------------------------------
module result_shadow_regs
  import conv_disp_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [RES_W-1:0]             wr_data,
  input  logic                         clr,
  output logic [NUM_RESULTS*RES_W-1:0] rd_data
);

  logic [RES_W-1:0] mem_q [NUM_RESULTS];
  logic [RES_W-1:0] mem_d [NUM_RESULTS];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < NUM_RESULTS; i++) mem_d[i] = '0;
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // NOTE: this small register array is reset like any other state so a reset
  // mid-frame can never leak stale bytes into a later publication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_RESULTS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RESULTS; i++) rd_data[i*RES_W +: RES_W] = mem_q[i];
  end

endmodule

// File: rtl/conv_result_collector.sv
// ---------------------------------------------------------------------------
// conv_result_collector
// Collects an 8-beat result frame from the convolution engine into a shadow
// buffer, then publishes all eight bytes at once for the display controller.
//   clk, reset        : clock, asynchronous active-low reset
//   res_valid/res_data/res_last : upstream beat, qualified by res_ready
//   abort             : synchronous frame abort (honoured in IDLE/COLLECT)
//   res_ready         : beat accepted this cycle (IDLE or COLLECT)
//   C_*_2x2, C_*_3x3  : published results, stable between publications
//   start_d           : one-cycle pulse, new published set valid
//   frame_err         : one-cycle pulse, short frame discarded
//   frame_cnt         : published frame count, wraps 15->0
// ---------------------------------------------------------------------------
module conv_result_collector
  import conv_disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res_data,
  input  logic             res_last,
  input  logic             abort,
  output logic             res_ready,
  output logic [RES_W-1:0] C_11_2x2,
  output logic [RES_W-1:0] C_12_2x2,
  output logic [RES_W-1:0] C_21_2x2,
  output logic [RES_W-1:0] C_22_2x2,
  output logic [RES_W-1:0] C_11_3x3,
  output logic [RES_W-1:0] C_12_3x3,
  output logic [RES_W-1:0] C_21_3x3,
  output logic [RES_W-1:0] C_22_3x3,
  output logic             start_d,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [RES_W-1:0]             pub_q [NUM_RESULTS];
  logic [RES_W-1:0]             pub_d [NUM_RESULTS];
  logic                         start_pulse_q, start_pulse_d;
  logic                         frame_err_q, frame_err_d;
  logic [CNT_W-1:0]             frame_cnt_q, frame_cnt_d;
  logic [NUM_RESULTS*RES_W-1:0] shadow_flat;
  logic                         accept;
  logic                         short_frame;

  // res_ready depends only on state, so it is the single output that is not
  // a flop yet still carries no combinational path from the inputs.
  assign res_ready   = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  // An abort in the same cycle drops the beat.
  assign accept      = res_valid & res_ready & ~abort;
  assign short_frame = accept & res_last & (idx_q != LAST_IDX);

  result_shadow_regs u_shadow (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_idx  (idx_q),
    .wr_data (res_data),
    .clr     (short_frame),
    .rd_data (shadow_flat)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pub_d         = pub_q;
    start_pulse_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (res_valid) begin
          if (idx_q == LAST_IDX) begin
            // The eighth beat always completes the frame, res_last or not.
            state_d = ST_PUBLISH;
            idx_d   = '0;
          end else if (res_last) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_PUBLISH: begin
        for (int i = 0; i < NUM_RESULTS; i++) pub_d[i] = shadow_flat[i*RES_W +: RES_W];
        start_pulse_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 1'b1;
        state_d       = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      for (int i = 0; i < NUM_RESULTS; i++) pub_q[i] <= '0;
      start_pulse_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pub_q         <= pub_d;
      start_pulse_q <= start_pulse_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign C_11_2x2  = pub_q[IDX_C11_2X2];
  assign C_12_2x2  = pub_q[IDX_C12_2X2];
  assign C_21_2x2  = pub_q[IDX_C21_2X2];
  assign C_22_2x2  = pub_q[IDX_C22_2X2];
  assign C_11_3x3  = pub_q[IDX_C11_3X3];
  assign C_12_3x3  = pub_q[IDX_C12_3X3];
  assign C_21_3x3  = pub_q[IDX_C21_3X3];
  assign C_22_3x3  = pub_q[IDX_C22_3X3];
  assign start_d   = start_pulse_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// ---------------------------------------------------------------------------
// tb_conv_result_collector
// Directed bench for conv_result_collector: reset, back-to-back and gapped
// frames, short frame, abort, asynchronous reset mid-frame, frame_cnt wrap.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_conv_result_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_last;
  logic       abort;
  logic       res_ready;
  logic [7:0] c_vec [8];
  logic       start_d;
  logic       frame_err;
  logic [3:0] frame_cnt;

  int         total = 0;
  int         bad = 0;
  int         start_seen = 0;
  int         err_seen = 0;
  logic [7:0] exp_c [8];
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  conv_result_collector dut (
    .clk       (clk),
    .reset     (reset),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_last  (res_last),
    .abort     (abort),
    .res_ready (res_ready),
    .C_11_2x2  (c_vec[0]),
    .C_12_2x2  (c_vec[1]),
    .C_21_2x2  (c_vec[2]),
    .C_22_2x2  (c_vec[3]),
    .C_11_3x3  (c_vec[4]),
    .C_12_3x3  (c_vec[5]),
    .C_21_3x3  (c_vec[6]),
    .C_22_3x3  (c_vec[7]),
    .start_d   (start_d),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always @(negedge clk) begin
    if (start_d === 1'b1) start_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_c%0d", tag, i), c_vec[i], exp_c[i]);
  endtask

  // One beat presented for exactly one cycle; caller is at edge+1.
  task automatic beat(input logic [7:0] d, input logic l);
    res_valid = 1'b1;
    res_data  = d;
    res_last  = l;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    res_last  = 1'b0;
  endtask

  // Eight beats base..base+7, last on the eighth. Optional random gaps, and
  // an optional check mid-frame that outputs still hold the previous frame.
  task automatic send_frame(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      beat(base + 8'(i), i == 7);
      if (gaps && i == 3) check_outs("hold");
      if (gaps && i < 7) begin
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Called at edge+1 right after the index-7 transfer: PUBLISH, DONE, IDLE.
  task automatic publish_check(input logic [7:0] base, input string tag);
    int s0;
    s0 = start_seen;
    for (int i = 0; i < 8; i++) exp_c[i] = base + 8'(i);
    exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    check({tag, "_pub_ready"}, res_ready, 1'b0);
    check({tag, "_pub_start"}, start_d, 1'b0);
    @(negedge clk);
    check({tag, "_done_ready"}, res_ready, 1'b0);
    check({tag, "_done_start"}, start_d, 1'b1);
    check({tag, "_done_cnt"}, frame_cnt, exp_cnt);
    check_outs({tag, "_done"});
    @(negedge clk);
    check({tag, "_idle_ready"}, res_ready, 1'b1);
    check({tag, "_idle_start"}, start_d, 1'b0);
    check({tag, "_start_once"}, start_seen, s0 + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, e0;
    reset     = 1'b0;
    res_valid = 1'b0;
    res_data  = 8'h00;
    res_last  = 1'b0;
    abort     = 1'b0;
    exp_cnt   = 4'd0;
    for (int i = 0; i < 8; i++) exp_c[i] = 8'h00;

    // Reset state
    #1;
    check_outs("in_reset");
    check("in_reset_start", start_d, 1'b0);
    check("in_reset_err", frame_err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_outs("post_reset");
    check("post_reset_cnt", frame_cnt, 4'd0);
    check("post_reset_ready", res_ready, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_start", start_seen, 0);
    check("idle_no_err", err_seen, 0);

    // Back-to-back frame 0x01..0x08
    send_frame(8'h01, 1'b0);
    publish_check(8'h01, "b2b");

    // Gapped frame 0x10..0x17 with hold check
    send_frame(8'h10, 1'b1);
    publish_check(8'h10, "gap");

    // Short frame: last on the third beat
    e0 = err_seen;
    s0 = start_seen;
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b1);
    @(negedge clk);
    check("short_err_hi", frame_err, 1'b1);
    @(negedge clk);
    check("short_err_lo", frame_err, 1'b0);
    check("short_err_once", err_seen, e0 + 1);
    check("short_no_start", start_seen, s0);
    check("short_cnt", frame_cnt, exp_cnt);
    check("short_ready", res_ready, 1'b1);
    check_outs("short_hold");
    @(posedge clk);
    #1;
    send_frame(8'h21, 1'b0);
    publish_check(8'h21, "after_short");

    // Abort after five beats, with a beat presented alongside the abort
    e0 = err_seen;
    s0 = start_seen;
    for (int i = 0; i < 5; i++) beat(8'h31 + 8'(i), 1'b0);
    abort     = 1'b1;
    res_valid = 1'b1;
    res_data  = 8'h99;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    res_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_start", start_seen, s0);
    check("abort_no_err", err_seen, e0);
    check("abort_cnt", frame_cnt, exp_cnt);
    check_outs("abort_hold");
    send_frame(8'h41, 1'b0);
    publish_check(8'h41, "after_abort");

    // Asynchronous reset during the sixth beat
    s0 = start_seen;
    for (int i = 0; i < 5; i++) beat(8'h51 + 8'(i), 1'b0);
    res_valid = 1'b1;
    res_data  = 8'h56;
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_c[i] = 8'h00;
    exp_cnt = 4'd0;
    check_outs("async_rst");
    check("async_rst_cnt", frame_cnt, 4'd0);
    res_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_start", start_seen, s0);
    check_outs("rst_stays_zero");

    // Sixteen frames: frame_cnt wraps 15 -> 0
    for (int f = 0; f < 16; f++) begin
      send_frame(8'(f * 16 + 3), f[0]);
      publish_check(8'(f * 16 + 3), $sformatf("wrap%0d", f));
    end
    check("wrap_cnt_zero", frame_cnt, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
